// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: load/store sequencer between the MEM pipeline stage and a byte-addressed data
// memory. Each access goes through these steps:
//   - decode the RISC-V access width;
//   - check the address against the memory window;
//   - split misaligned H/W accesses into byte accesses (optional);
//   - sign- or zero-extend the load result.
// The pipeline is stalled until the one-cycle completion pulse.
//
// Ports:
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_mem_req                MEM stage request (level, held until o_mem_done)
//   i_mem_we                 1 = store, 0 = load
//   i_mem_funct3             000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_mem_addr, i_mem_wdata  byte address, LSB-aligned store data
//   o_mem_stall              freeze the pipeline
//   o_mem_done               one-cycle completion pulse
//   o_mem_rdata, o_mem_fault extended load data / rejection flag, valid with o_mem_done
//   o_dmem_*                 address, write strobe, write data, size (0 B, 1 H, 2 W) to memory
//   i_dmem_data_out          combinational read data from memory
module dmem_lsu_ctrl #(
    parameter logic [31:0] BASE_ADDR        = 32'h0100_0000,
    parameter int unsigned MEM_BYTES        = 1048576,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [2:0]  i_mem_funct3,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic        o_mem_stall,
    output logic        o_mem_done,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_fault,
    output logic [31:0] o_dmem_address,
    output logic        o_dmem_read_write,
    output logic [31:0] o_dmem_data_in,
    output logic [1:0]  o_dmem_access_size,
    input  logic [31:0] i_dmem_data_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_SPLIT  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // One past the last valid byte; 33 bits so addr + N near 2^32 cannot wrap.
    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);

    logic [1:0]  r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic [1:0]  r_cnt;
    logic [31:0] r_asm;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_data;
    logic [1:0]  r_dmem_size;

    // Request decode (IDLE only)
    logic [1:0]  w_req_size;
    logic [2:0]  w_req_nbytes;
    logic        w_bad_f3;
    logic        w_bad_store;
    logic        w_addr_lo;
    logic        w_addr_hi;
    logic        w_misalign;
    logic        w_fault;

    always_comb begin
        unique case (i_mem_funct3[1:0])
            2'b00:   w_req_size = 2'd0;
            2'b01:   w_req_size = 2'd1;
            default: w_req_size = 2'd2;
        endcase
    end

    assign w_req_nbytes = (w_req_size == 2'd0) ? 3'd1 : (w_req_size == 2'd1) ? 3'd2 : 3'd4;
    assign w_bad_f3     = (i_mem_funct3 == 3'b011) || (i_mem_funct3[2:1] == 2'b11);
    assign w_bad_store  = i_mem_we && i_mem_funct3[2];
    assign w_addr_lo    = {1'b0, i_mem_addr} < {1'b0, BASE_ADDR};
    assign w_addr_hi    = ({1'b0, i_mem_addr} + {30'd0, w_req_nbytes}) > WIN_END;
    assign w_misalign   = ((w_req_size == 2'd1) && i_mem_addr[0]) ||
                          ((w_req_size == 2'd2) && (i_mem_addr[1:0] != 2'b00));
    assign w_fault      = w_bad_f3 || w_bad_store || w_addr_lo || w_addr_hi ||
                          (w_misalign && !SPLIT_MISALIGNED);

    // Latched-access helpers: last byte index is N-1 (0, 1 or 3)
    logic [1:0] w_last;
    logic [1:0] w_cnt_next;
    logic [7:0] w_wbyte_next;

    assign w_last       = {r_funct3[1], r_funct3[1] | r_funct3[0]};
    assign w_cnt_next   = r_cnt + 2'd1;
    assign w_wbyte_next = r_wdata[{w_cnt_next, 3'b000} +: 8];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_fault     <= 1'b0;
            r_cnt       <= 2'd0;
            r_asm       <= 32'd0;
            r_dmem_addr <= BASE_ADDR;
            r_dmem_data <= 32'd0;
            r_dmem_size <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_mem_req) begin
                        r_we     <= i_mem_we;
                        r_funct3 <= i_mem_funct3;
                        r_addr   <= i_mem_addr;
                        r_wdata  <= i_mem_wdata;
                        r_fault  <= w_fault;
                        r_cnt    <= 2'd0;
                        r_asm    <= 32'd0;
                        if (w_fault) begin
                            // Memory-side outputs keep their previous values
                            r_state <= S_DONE;
                        end else if (w_misalign) begin
                            r_state     <= S_SPLIT;
                            r_dmem_addr <= i_mem_addr;
                            r_dmem_size <= 2'd0;
                            r_dmem_data <= {24'd0, i_mem_wdata[7:0]};
                        end else begin
                            r_state     <= S_ACCESS;
                            r_dmem_addr <= i_mem_addr;
                            r_dmem_size <= w_req_size;
                            r_dmem_data <= i_mem_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    r_asm   <= i_dmem_data_out;
                    r_state <= S_DONE;
                end
                S_SPLIT: begin
                    if (!r_we) begin
                        r_asm[{r_cnt, 3'b000} +: 8] <= i_dmem_data_out[7:0];
                    end
                    if (r_cnt == w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt       <= w_cnt_next;
                        r_dmem_addr <= r_addr + {30'd0, w_cnt_next};
                        r_dmem_data <= {24'd0, w_wbyte_next};
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_dmem_address     = r_dmem_addr;
    assign o_dmem_data_in     = r_dmem_data;
    assign o_dmem_access_size = r_dmem_size;
    // Reset gates the strobe so an interrupted split stops writing in the reset cycle itself
    assign o_dmem_read_write  = !i_reset && r_we &&
                                ((r_state == S_ACCESS) || (r_state == S_SPLIT));

    assign o_mem_done  = (r_state == S_DONE);
    assign o_mem_fault = o_mem_done && r_fault;
    assign o_mem_stall = i_mem_req && !o_mem_done;

    always_comb begin
        o_mem_rdata = 32'd0;
        if (o_mem_done && !r_we && !r_fault) begin
            case (r_funct3)
                3'b000:  o_mem_rdata = {{24{r_asm[7]}}, r_asm[7:0]};
                3'b001:  o_mem_rdata = {{16{r_asm[15]}}, r_asm[15:0]};
                3'b100:  o_mem_rdata = {24'd0, r_asm[7:0]};
                3'b101:  o_mem_rdata = {16'd0, r_asm[15:0]};
                default: o_mem_rdata = r_asm;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Testbench for dmem_lsu_ctrl: directed stimulus with a byte memory model; expected responses
// are queued at issue time and checked by a separate monitor on each o_mem_done pulse.
module tb_dmem_lsu_ctrl;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam int unsigned MEMB = 1048576;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] d_addr;
    logic        d_rw;
    logic [31:0] d_din;
    logic [1:0]  d_size;
    logic [31:0] d_dout;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
        int unsigned done_cyc;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } wr_t;

    exp_t  expq[$];
    string nameq[$];
    wr_t   wlog[$];

    dmem_lsu_ctrl #(
        .BASE_ADDR        (BASE),
        .MEM_BYTES        (MEMB),
        .SPLIT_MISALIGNED (1'b1)
    ) dut (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_mem_req          (req),
        .i_mem_we           (we),
        .i_mem_funct3       (f3),
        .i_mem_addr         (addr),
        .i_mem_wdata        (wdata),
        .o_mem_stall        (stall),
        .o_mem_done         (done),
        .o_mem_rdata        (rdata),
        .o_mem_fault        (fault),
        .o_dmem_address     (d_addr),
        .o_dmem_read_write  (d_rw),
        .o_dmem_data_in     (d_din),
        .o_dmem_access_size (d_size),
        .i_dmem_data_out    (d_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory model: low 8 address bits select the byte, little-endian
    logic [7:0] mem [0:255];
    logic       mem_init;
    logic [7:0] ra;
    wr_t        wr_new;

    assign ra     = d_addr[7:0];
    assign d_dout = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (d_rw) begin
            wr_new.addr = d_addr;
            wr_new.data = d_din;
            wr_new.size = d_size;
            wlog.push_back(wr_new);
            mem[ra] <= d_din[7:0];
            if (d_size != 2'd0) mem[ra + 8'd1] <= d_din[15:8];
            if (d_size == 2'd2) begin
                mem[ra + 8'd2] <= d_din[23:16];
                mem[ra + 8'd3] <= d_din[31:24];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: one pop per completion pulse
    exp_t  mon_e;
    string mon_n;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc);
            end else begin
                mon_e = expq.pop_front();
                mon_n = nameq.pop_front();
                check({mon_n, "_rdata"}, rdata, mon_e.rdata);
                check({mon_n, "_fault"}, {31'd0, fault}, {31'd0, mon_e.fault});
                check({mon_n, "_done_cycle"}, cyc, mon_e.done_cyc);
            end
        end
    end

    // Called #1 after a posedge. pre = edges until the accepting edge; lat = edges from the
    // accepting edge to the edge after which o_mem_done is visible.
    task automatic issue(input string name, input logic we_i, input logic [2:0] f3_i,
                         input logic [31:0] a_i, input logic [31:0] wd_i,
                         input logic [31:0] exp_rd, input logic exp_flt,
                         input int unsigned lat, input int pre, input bit drop_early,
                         input bit hold_after, output int unsigned acc);
        exp_t e;
        bit   seen;
        req   = 1'b1;
        we    = we_i;
        f3    = f3_i;
        addr  = a_i;
        wdata = wd_i;
        if (pre == 1) begin
            #1;
            check({name, "_stall_req"}, {31'd0, stall}, 32'd1);
        end
        repeat (pre) @(posedge clk);
        #1;
        acc        = cyc;
        e.rdata    = exp_rd;
        e.fault    = exp_flt;
        e.done_cyc = acc + lat;
        expq.push_back(e);
        nameq.push_back(name);
        if (drop_early) begin
            req = 1'b0;
        end else if (lat > 0) begin
            check({name, "_stall_busy"}, {31'd0, stall}, 32'd1);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end else if (!drop_early) begin
            check({name, "_stall_done"}, {31'd0, stall}, 32'd0);
        end
        if (!hold_after) begin
            req = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    int unsigned acc0;
    int unsigned acc1;

    initial begin
        rst      = 1'b1;
        mem_init = 1'b1;
        req      = 1'b0;
        we       = 1'b0;
        f3       = 3'b000;
        addr     = 32'd0;
        wdata    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rw", {31'd0, d_rw}, 32'd0);
        check("rst_addr", d_addr, BASE);
        check("rst_din", d_din, 32'd0);
        check("rst_size", {30'd0, d_size}, 32'd0);
        rst      = 1'b0;
        mem_init = 1'b0;

        // Aligned store then load
        wlog.delete();
        issue("sw_al", 1'b1, 3'b010, BASE, 32'hDEAD_BEEF, 32'd0, 1'b0, 1, 1, 0, 0, acc0);
        check("sw_al_nwr", wlog.size(), 32'd1);
        if (wlog.size() > 0) begin
            check("sw_al_wsize", {30'd0, wlog[0].size}, 32'd2);
            check("sw_al_waddr", wlog[0].addr, BASE);
        end
        check("sw_al_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'hDEAD_BEEF);
        issue("lw_al", 1'b0, 3'b010, BASE, 32'd0, 32'hDEAD_BEEF, 1'b0, 1, 1, 0, 0, acc0);

        // Extension
        issue("lb", 1'b0, 3'b000, BASE + 32'd3, 32'd0, 32'hFFFF_FFDE, 1'b0, 1, 1, 0, 0, acc0);
        issue("lbu", 1'b0, 3'b100, BASE + 32'd3, 32'd0, 32'h0000_00DE, 1'b0, 1, 1, 0, 0, acc0);
        issue("lh", 1'b0, 3'b001, BASE + 32'd2, 32'd0, 32'hFFFF_DEAD, 1'b0, 1, 1, 0, 0, acc0);
        issue("lhu", 1'b0, 3'b101, BASE + 32'd2, 32'd0, 32'h0000_DEAD, 1'b0, 1, 1, 0, 0, acc0);

        // Misaligned split
        wlog.delete();
        issue("sw_split", 1'b1, 3'b010, BASE + 32'd1, 32'h1122_3344, 32'd0, 1'b0, 4, 1, 0, 0,
              acc0);
        check("sw_split_nwr", wlog.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (wlog.size() > k) begin
                check($sformatf("sw_split_addr%0d", k), wlog[k].addr, BASE + 32'd1 + 32'(k));
                check($sformatf("sw_split_byte%0d", k), {22'd0, wlog[k].size, wlog[k].data[7:0]},
                      {24'd0, 8'h44 - 8'(k * 8'h11)});
            end
        end
        check("sw_split_mem", {mem[4], mem[3], mem[2], mem[1]}, 32'h1122_3344);
        issue("lw_split", 1'b0, 3'b010, BASE + 32'd1, 32'd0, 32'h1122_3344, 1'b0, 4, 1, 0, 0,
              acc0);
        issue("lh_split", 1'b0, 3'b001, BASE + 32'd3, 32'd0, 32'h0000_1122, 1'b0, 2, 1, 0, 0,
              acc0);

        // Faults and window boundaries
        wlog.delete();
        issue("lw_below", 1'b0, 3'b010, 32'h00FF_FFFC, 32'd0, 32'd0, 1'b1, 0, 1, 0, 0, acc0);
        issue("sw_above", 1'b1, 3'b010, BASE + MEMB - 32'd2, 32'h1234_5678, 32'd0, 1'b1, 0, 1,
              0, 0, acc0);
        issue("f3_011", 1'b0, 3'b011, BASE, 32'd0, 32'd0, 1'b1, 0, 1, 0, 0, acc0);
        issue("st_bu", 1'b1, 3'b100, BASE + 32'd8, 32'h0000_00AA, 32'd0, 1'b1, 0, 1, 0, 0, acc0);
        issue("lw_wrap", 1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1, 0, 1, 0, 0, acc0);
        issue("lw_last", 1'b0, 3'b010, BASE + MEMB - 32'd4, 32'd0, 32'd0, 1'b0, 1, 1, 0, 0, acc0);
        check("fault_nwr", wlog.size(), 32'd0);

        // Reset during the second byte of a split store
        wlog.delete();
        req   = 1'b1;
        we    = 1'b1;
        f3    = 3'b010;
        addr  = BASE + 32'h11;
        wdata = 32'hAABB_CCDD;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 1'b0;
        #1;
        check("rstmid_rw_forced", {31'd0, d_rw}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmid_done", {31'd0, done}, 32'd0);
        check("rstmid_fault", {31'd0, fault}, 32'd0);
        check("rstmid_rdata", rdata, 32'd0);
        check("rstmid_rw", {31'd0, d_rw}, 32'd0);
        check("rstmid_addr", d_addr, BASE);
        check("rstmid_din", d_din, 32'd0);
        check("rstmid_size", {30'd0, d_size}, 32'd0);
        check("rstmid_nwr", wlog.size(), 32'd1);
        check("rstmid_b0", {24'd0, mem[8'h11]}, 32'h0000_00DD);
        check("rstmid_b1", {24'd0, mem[8'h12]}, 32'h0000_0000);
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back loads; the second drops mem_req right after acceptance
        issue("lw_b2b0", 1'b0, 3'b010, BASE + 32'd4, 32'd0, 32'h0000_0011, 1'b0, 1, 1, 0, 1,
              acc0);
        issue("lw_b2b1", 1'b0, 3'b010, BASE, 32'd0, 32'h2233_44EF, 1'b0, 1, 2, 1, 0, acc1);
        check("b2b_gap", acc1 - acc0, 32'd3);

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
